piso_tx: RTL and testbench



---
 rtl/piso_tx_pkg.sv | 14 +
 rtl/piso_tx_dff_r.sv | 21 ++
 rtl/piso_tx.sv | 89 ++++++++
 tb/tb_piso_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// Shared definitions for the serial transmitter: FSM state encodings and a
// sizing helper for the internal counters.
package piso_tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_tx_dff_r.sv
// Single-bit D flip-flop with asynchronous active-low reset. Both q and qbar
// are derived from the one stored bit so they can never disagree.
module dff_r (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic qb_o
);

    logic q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= 1'b0;
        else        q_q <= d_i;
    end

    assign q_o  = q_q;
    assign qb_o = ~q_q;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a word on valid/ready and shifts
// it out one bit per clock with frame and last-bit markers.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int GAP       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sdata,
    output logic             sdata_n,
    output logic             sframe,
    output logic             done
);

    localparam int CW = cnt_w(WIDTH);
    localparam int GW = cnt_w(GAP + 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             last, accept, sbit_d;

    assign last   = (cnt_q == CW'(WIDTH - 1));
    assign accept = din_valid && din_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            sr_q    <= sr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SHIFT;
            ST_SHIFT: if (last && !accept) state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:   if (gcnt_q == GW'(GAP - 1)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: the register always presents the next bit to send at the top
    // (MSB-first) or bottom (LSB-first), so the output flop can be fed directly.
    always_comb begin
        cnt_d  = cnt_q;
        sr_d   = sr_q;
        gcnt_d = '0;
        if (accept) begin
            sr_d  = din;
            cnt_d = '0;
        end else if (state_q == ST_SHIFT) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
            sr_d  = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
        end
        if (state_q == ST_GAP) gcnt_d = gcnt_q + 1'b1;
        sbit_d = 1'b0;
        if (state_d == ST_SHIFT) sbit_d = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];
    end

    always_comb begin
        sframe    = (state_q == ST_SHIFT);
        done      = sframe && last;
        din_ready = (state_q == ST_IDLE) || ((GAP == 0) && sframe && last);
    end

    dff_r u_out (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (sbit_d),
        .q_o  (sdata),
        .qb_o (sdata_n)
    );

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: four configurations driven side by side and checked
// against a per-cycle timeline of expected outputs built at each handshake.
module tb_piso_tx;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int NC = 2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] din [N];
    logic vld [N], rdy [N], sd [N], sdn [N], sf [N], dn [N];

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .GAP(1), .MSB_FIRST(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .din(din[0]),
        .din_valid(vld[0]), .din_ready(rdy[0]), .sdata(sd[0]), .sdata_n(sdn[0]), .sframe(sf[0]), .done(dn[0]));
    piso_tx #(.WIDTH(W), .GAP(1), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .din(din[1]),
        .din_valid(vld[1]), .din_ready(rdy[1]), .sdata(sd[1]), .sdata_n(sdn[1]), .sframe(sf[1]), .done(dn[1]));
    piso_tx #(.WIDTH(W), .GAP(0), .MSB_FIRST(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .din(din[2]),
        .din_valid(vld[2]), .din_ready(rdy[2]), .sdata(sd[2]), .sdata_n(sdn[2]), .sframe(sf[2]), .done(dn[2]));
    piso_tx #(.WIDTH(W), .GAP(3), .MSB_FIRST(1'b1)) u3 (.clk(clk), .rst_n(rst_n), .din(din[3]),
        .din_valid(vld[3]), .din_ready(rdy[3]), .sdata(sd[3]), .sdata_n(sdn[3]), .sframe(sf[3]), .done(dn[3]));

    int gapv [N] = '{1, 1, 0, 3};
    bit msbv [N] = '{1'b1, 1'b0, 1'b1, 1'b1};

    // Expected timeline: per instance, per cycle index.
    bit e_sd [N][NC];
    bit e_sf [N][NC];
    bit e_dn [N][NC];
    int free_at [N];
    int cyc;
    int checks = 0;
    int errors = 0;
    int frames = 0;

    logic [W-1:0] nd [N];
    bit nv [N];

    task automatic chk(input string tag, input int inst, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s[%0d] cyc=%0d observed=%0b expected=%0b", tag, inst, cyc, obs, expv);
        end
    endtask

    task automatic chk_reset_state();
        for (int i = 0; i < N; i++) begin
            chk("rst_sdata", i, sd[i], 1'b0);
            chk("rst_sdata_n", i, sdn[i], 1'b1);
            chk("rst_sframe", i, sf[i], 1'b0);
            chk("rst_done", i, dn[i], 1'b0);
            chk("rst_ready", i, rdy[i], 1'b1);
        end
    endtask

    // Present nd/nv for the coming edge, record handshakes in the model,
    // advance one clock and compare every output with the timeline.
    task automatic step();
        for (int i = 0; i < N; i++) begin
            din[i] = nd[i];
            vld[i] = nv[i];
            if (nv[i] && cyc >= free_at[i]) begin
                frames++;
                for (int k = 0; k < W; k++) begin
                    e_sd[i][cyc+1+k] = msbv[i] ? nd[i][W-1-k] : nd[i][k];
                    e_sf[i][cyc+1+k] = 1'b1;
                    e_dn[i][cyc+1+k] = (k == W - 1);
                end
                free_at[i] = (gapv[i] == 0) ? cyc + W : cyc + W + gapv[i] + 1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            chk("sdata", i, sd[i], e_sd[i][cyc]);
            chk("sdata_n", i, sdn[i], ~e_sd[i][cyc]);
            chk("sframe", i, sf[i], e_sf[i][cyc]);
            chk("done", i, dn[i], e_dn[i][cyc]);
            chk("ready", i, rdy[i], cyc >= free_at[i]);
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            nv[i] = 1'b0;
            nd[i] = W'($urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            din[i] = '0;
            vld[i] = 1'b0;
            free_at[i] = 0;
            for (int c = 0; c < NC; c++) begin
                e_sd[i][c] = 1'b0; e_sf[i][c] = 1'b0; e_dn[i][c] = 1'b0;
            end
        end
        cyc = 0;
        #12;
        chk_reset_state();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: A5 MSB-first, 01 LSB-first, F0/0F back-to-back, two words with GAP=3.
        idle_all();
        nv[0] = 1'b1; nd[0] = 8'hA5;
        nv[1] = 1'b1; nd[1] = 8'h01;
        nv[2] = 1'b1; nd[2] = 8'hF0;
        nv[3] = 1'b1; nd[3] = 8'h3C;
        step();
        for (int s = 0; s < 20; s++) begin
            nd[0] = W'($urandom); nv[0] = 1'b0;
            nd[1] = W'($urandom); nv[1] = 1'b0;
            nd[2] = 8'h0F;        nv[2] = (s < 8);
            nd[3] = 8'hC3;        nv[3] = 1'b1;
            step();
        end

        // Toggle din every cycle and pulse valid while a frame is in flight.
        idle_all();
        for (int i = 0; i < N; i++) begin nv[i] = 1'b1; nd[i] = 8'h5A; end
        step();
        for (int s = 0; s < 14; s++) begin
            for (int i = 0; i < N; i++) begin
                nd[i] = ~nd[i];
                nv[i] = s[0];
            end
            step();
        end
        idle_all();
        for (int s = 0; s < 6; s++) step();

        // Asynchronous reset in the middle of an FF frame.
        for (int i = 0; i < N; i++) begin nv[i] = 1'b1; nd[i] = 8'hFF; end
        step();
        idle_all();
        for (int s = 0; s < 3; s++) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        @(posedge clk);
        cyc++;
        #1;
        chk_reset_state();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            free_at[i] = cyc;
            for (int c = cyc; c < NC; c++) begin
                e_sd[i][c] = 1'b0; e_sf[i][c] = 1'b0; e_dn[i][c] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin nv[i] = 1'b1; nd[i] = 8'h81; end
        step();
        idle_all();
        for (int s = 0; s < 12; s++) step();

        // Randomized traffic, valid biased high, din changing freely.
        for (int s = 0; s < 1500; s++) begin
            for (int i = 0; i < N; i++) begin
                nv[i] = ($urandom_range(0, 3) != 0);
                nd[i] = W'($urandom);
            end
            step();
        end
        idle_all();
        for (int s = 0; s < 12; s++) step();

        if (frames < 50) begin
            errors++;
            $error("FAIL frame_count observed=%0d required>=50", frames);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
